// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC programming writer: register index map,
// RTC bus address table, FSM state encodings and the mask-scan helper.
package rtc_pkg;

    localparam int NUM_REGS = 9;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 8;

    // Register indices, matching the bit order of wr_mask and the byte order of dato_bcd
    localparam logic [IDX_W-1:0] IDX_SEG    = 4'd0;
    localparam logic [IDX_W-1:0] IDX_MIN    = 4'd1;
    localparam logic [IDX_W-1:0] IDX_HORA   = 4'd2;
    localparam logic [IDX_W-1:0] IDX_DIA    = 4'd3;
    localparam logic [IDX_W-1:0] IDX_MES    = 4'd4;
    localparam logic [IDX_W-1:0] IDX_ANIO   = 4'd5;
    localparam logic [IDX_W-1:0] IDX_SEG_T  = 4'd6;
    localparam logic [IDX_W-1:0] IDX_MIN_T  = 4'd7;
    localparam logic [IDX_W-1:0] IDX_HORA_T = 4'd8;

    // Per-register bus transfer phases
    typedef enum logic [2:0] {
        WR_IDLE,
        WR_ADDR_LO,
        WR_ADDR_HI,
        WR_DATA_LO,
        WR_DATA_HI,
        WR_GAP
    } wr_state_t;

    // Burst-level sequencing
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_FIN
    } pw_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } scan_t;

    // RTC chip register address for a programming value index
    function automatic logic [7:0] reg_addr(input logic [IDX_W-1:0] idx);
        logic [7:0] a;
        case (idx)
            IDX_SEG:    a = 8'h21;
            IDX_MIN:    a = 8'h22;
            IDX_HORA:   a = 8'h23;
            IDX_DIA:    a = 8'h24;
            IDX_MES:    a = 8'h25;
            IDX_ANIO:   a = 8'h26;
            IDX_SEG_T:  a = 8'h41;
            IDX_MIN_T:  a = 8'h42;
            IDX_HORA_T: a = 8'h43;
            default:    a = 8'h00;
        endcase
        return a;
    endfunction

    // Lowest set bit of a write mask, with a flag for the empty mask
    function automatic scan_t lowest_set(input logic [NUM_REGS-1:0] mask);
        scan_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_prog_writer_if.sv
// Multiplexed address/data bus towards the RTC pad drivers.
interface rtc_prog_writer_if;

    logic [7:0] ad_out;
    logic       ad_oe;
    logic       a_d;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;

    modport master (output ad_out, ad_oe, a_d, cs_n, wr_n, rd_n);
    modport slave  (input  ad_out, ad_oe, a_d, cs_n, wr_n, rd_n);

endinterface

// File: rtl/rtc_bus_write_cycle.sv
// One address+data write transfer on the RTC bus. A request is taken in
// WR_IDLE or in the last GAP cycle, so consecutive transfers run with no
// dead cycle. All bus outputs are registered and decoded from the state
// being entered. A single down-counter times every phase.
module rtc_bus_write_cycle
    import rtc_pkg::*;
#(
    parameter int T_LOW  = 4,
    parameter int T_HIGH = 4,
    parameter int T_GAP  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] data_i,
    output logic       ack_o,
    output logic [7:0] ad_out_o,
    output logic       ad_oe_o,
    output logic       a_d_o,
    output logic       cs_n_o,
    output logic       wr_n_o
);

    localparam logic [CNT_W-1:0] LOW_LD  = CNT_W'(T_LOW - 1);
    localparam logic [CNT_W-1:0] HIGH_LD = CNT_W'(T_HIGH - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(T_GAP - 1);

    wr_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ad_out_q, ad_out_d;
    logic             ad_oe_q, ad_oe_d;
    logic             a_d_q, a_d_d;
    logic             cs_n_q, cs_n_d;
    logic             wr_n_q, wr_n_d;

    // Transfer finishes on the edge that ends the last GAP cycle
    assign ack_o = (state_q == WR_GAP) && (cnt_q == '0);

    // Phase sequencing, counter reload and registered bus decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        ad_out_d = ad_out_q;

        unique case (state_q)
            WR_IDLE: begin
                if (req_i) begin
                    state_d  = WR_ADDR_LO;
                    cnt_d    = LOW_LD;
                    ad_out_d = addr_i;
                end
            end
            WR_ADDR_LO: begin
                if (cnt_q == '0) begin
                    state_d = WR_ADDR_HI;
                    cnt_d   = HIGH_LD;
                end
            end
            WR_ADDR_HI: begin
                if (cnt_q == '0) begin
                    state_d  = WR_DATA_LO;
                    cnt_d    = LOW_LD;
                    ad_out_d = data_i;
                end
            end
            WR_DATA_LO: begin
                if (cnt_q == '0) begin
                    state_d = WR_DATA_HI;
                    cnt_d   = HIGH_LD;
                end
            end
            WR_DATA_HI: begin
                if (cnt_q == '0) begin
                    state_d = WR_GAP;
                    cnt_d   = GAP_LD;
                end
            end
            WR_GAP: begin
                if (cnt_q == '0) begin
                    if (req_i) begin
                        state_d  = WR_ADDR_LO;
                        cnt_d    = LOW_LD;
                        ad_out_d = addr_i;
                    end else begin
                        state_d = WR_IDLE;
                    end
                end
            end
            default: state_d = WR_IDLE;
        endcase

        // Bus controls follow the phase being entered so they appear registered with it
        cs_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        a_d_d   = 1'b0;
        ad_oe_d = 1'b0;
        case (state_d)
            WR_ADDR_LO: begin
                cs_n_d  = 1'b0;
                ad_oe_d = 1'b1;
                wr_n_d  = 1'b0;
            end
            WR_ADDR_HI: begin
                cs_n_d  = 1'b0;
                ad_oe_d = 1'b1;
            end
            WR_DATA_LO: begin
                cs_n_d  = 1'b0;
                ad_oe_d = 1'b1;
                a_d_d   = 1'b1;
                wr_n_d  = 1'b0;
            end
            WR_DATA_HI: begin
                cs_n_d  = 1'b0;
                ad_oe_d = 1'b1;
                a_d_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Phase state, counter and bus output registers; reset drops the bus at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= WR_IDLE;
            cnt_q    <= '0;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            a_d_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            a_d_q    <= a_d_d;
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
        end
    end

    assign ad_out_o = ad_out_q;
    assign ad_oe_o  = ad_oe_q;
    assign a_d_o    = a_d_q;
    assign cs_n_o   = cs_n_q;
    assign wr_n_o   = wr_n_q;

endmodule

// File: rtl/rtc_prog_writer.sv
// Writes the selected BCD programming values to the RTC chip. A start pulse
// snapshots the values and mask; the mask is then scanned from the lowest
// set bit upward, one bus transfer per selected register.
module rtc_prog_writer
    import rtc_pkg::*;
#(
    parameter int T_LOW  = 4,
    parameter int T_HIGH = 4,
    parameter int T_GAP  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NUM_REGS-1:0]     wr_mask,
    input  logic [8*NUM_REGS-1:0]   dato_bcd,
    rtc_prog_writer_if.master       bus,
    output logic                    busy,
    output logic                    done
);

    pw_state_t               state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_REGS-1:0]     mask_q, mask_d;
    logic [8*NUM_REGS-1:0]   data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    req;
    logic [7:0]              req_addr;
    logic [7:0]              req_data;
    logic                    xfer_ack;
    scan_t                   scan;
    logic [NUM_REGS-1:0]     written_bits;
    logic [NUM_REGS-1:0]     remaining;

    // Bits at or below the current index have already been written
    assign written_bits = (NUM_REGS'(2) << idx_q) - NUM_REGS'(1);
    assign remaining    = mask_q & ~written_bits;

    assign req_data = data_q[{idx_q, 3'b000} +: 8];

    // Burst sequencing: accept start, hand out the next selected register, finish
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        data_d  = data_q;
        req     = 1'b0;
        scan    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d = wr_mask;
                    data_d = dato_bcd;
                    scan   = lowest_set(wr_mask);
                    if (scan.found) begin
                        idx_d   = scan.idx;
                        req     = 1'b1;
                        state_d = ST_BURST;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_BURST: begin
                if (xfer_ack) begin
                    scan = lowest_set(remaining);
                    if (scan.found) begin
                        idx_d = scan.idx;
                        req   = 1'b1;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d   = (state_d == ST_BURST);
        done_d   = (state_d == ST_FIN);
        req_addr = reg_addr(idx_d);
    end

    // Burst state, snapshot and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    rtc_bus_write_cycle #(
        .T_LOW  (T_LOW),
        .T_HIGH (T_HIGH),
        .T_GAP  (T_GAP)
    ) u_wr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req),
        .addr_i   (req_addr),
        .data_i   (req_data),
        .ack_o    (xfer_ack),
        .ad_out_o (bus.ad_out),
        .ad_oe_o  (bus.ad_oe),
        .a_d_o    (bus.a_d),
        .cs_n_o   (bus.cs_n),
        .wr_n_o   (bus.wr_n)
    );

    // This block only ever writes
    assign bus.rd_n = 1'b1;

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_rtc_prog_writer.sv
// Bench for rtc_prog_writer: scoreboard of expected (address, data) writes,
// a bus monitor/protocol checker, and one task per scenario.
module tb_rtc_prog_writer;

    localparam int T_LOW  = 4;
    localparam int T_HIGH = 4;
    localparam int T_GAP  = 2;
    localparam int XFER   = 2 * (T_LOW + T_HIGH) + T_GAP;

    localparam logic [71:0] DATA_A = {8'h12, 8'h15, 8'h30, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h45};
    localparam logic [71:0] DATA_B = 72'h09_08_07_06_05_04_03_02_01;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [8:0]  wr_mask  = '0;
    logic [71:0] dato_bcd = '0;
    logic        busy;
    logic        done;

    rtc_prog_writer_if bus_if ();

    rtc_prog_writer #(
        .T_LOW  (T_LOW),
        .T_HIGH (T_HIGH),
        .T_GAP  (T_GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .wr_mask  (wr_mask),
        .dato_bcd (dato_bcd),
        .bus      (bus_if),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0]  addr_tbl [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];

    // Bus monitor and protocol checker, sampled on the falling edge
    initial begin
        int         lo_cnt;
        int         hi_cnt;
        logic       p_wr_n;
        logic       p_cs_n;
        logic       p_a_d;
        logic [7:0] p_ad;
        logic [7:0] cur_addr;
        lo_cnt = 0; hi_cnt = 0; p_wr_n = 1'b1; p_cs_n = 1'b1; p_a_d = 1'b0; p_ad = '0; cur_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                lo_cnt = 0; hi_cnt = 0; p_wr_n = 1'b1; p_cs_n = 1'b1; p_a_d = 1'b0; p_ad = '0; cur_addr = '0;
            end else begin
                checks++;
                if (bus_if.rd_n !== 1'b1) begin
                    errors++; $display("FAIL proto_rd_n t=%0t: rd_n=%b, required 1", $time, bus_if.rd_n);
                end
                checks++;
                if (bus_if.wr_n === 1'b0 && bus_if.cs_n !== 1'b0) begin
                    errors++; $display("FAIL proto_wr_cs t=%0t: wr_n low with cs_n=%b", $time, bus_if.cs_n);
                end
                if (p_wr_n === 1'b0 && bus_if.wr_n === 1'b1) begin
                    checks++;
                    if (bus_if.a_d !== p_a_d || bus_if.ad_out !== p_ad) begin
                        errors++;
                        $display("FAIL proto_stable t=%0t: a_d/ad_out %b/%h after strobe, required %b/%h",
                                 $time, bus_if.a_d, bus_if.ad_out, p_a_d, p_ad);
                    end
                    checks++;
                    if (lo_cnt != T_LOW) begin
                        errors++; $display("FAIL proto_low_width t=%0t: %0d cycles, required %0d", $time, lo_cnt, T_LOW);
                    end
                    if (bus_if.a_d === 1'b0) cur_addr = bus_if.ad_out;
                    else obs_q.push_back({cur_addr, bus_if.ad_out});
                end
                if ((p_wr_n === 1'b1 && bus_if.wr_n === 1'b0 && p_cs_n === 1'b0) ||
                    (p_cs_n === 1'b0 && bus_if.cs_n === 1'b1)) begin
                    checks++;
                    if (hi_cnt != T_HIGH) begin
                        errors++; $display("FAIL proto_high_width t=%0t: %0d cycles, required %0d", $time, hi_cnt, T_HIGH);
                    end
                end
                lo_cnt = (bus_if.wr_n === 1'b0) ? lo_cnt + 1 : 0;
                hi_cnt = (bus_if.wr_n === 1'b1 && bus_if.cs_n === 1'b0) ? hi_cnt + 1 : 0;
                p_wr_n = bus_if.wr_n; p_cs_n = bus_if.cs_n; p_a_d = bus_if.a_d; p_ad = bus_if.ad_out;
            end
        end
    end

    // Scoreboard fill: one entry per selected register, in index order
    task automatic push_expected(input logic [8:0] m, input logic [71:0] d);
        for (int i = 0; i < 9; i++)
            if (m[i]) exp_q.push_back({addr_tbl[i], d[8*i +: 8]});
    endtask

    // Pulse start for one cycle; returns the start cycle and leaves time at relative cycle 1
    task automatic start_burst(input logic [8:0] m, input logic [71:0] d, output int c0);
        @(posedge clk); #1;
        wr_mask = m; dato_bcd = d; start = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus_if.ad_out !== 8'h00) begin errors++; $display("FAIL reset_ad_out: %h, required 00", bus_if.ad_out); end
        checks++; if (bus_if.ad_oe !== 1'b0) begin errors++; $display("FAIL reset_ad_oe: %b, required 0", bus_if.ad_oe); end
        checks++; if (bus_if.a_d !== 1'b0) begin errors++; $display("FAIL reset_a_d: %b, required 0", bus_if.a_d); end
        checks++; if (bus_if.cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: %b, required 1", bus_if.cs_n); end
        checks++; if (bus_if.wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n: %b, required 1", bus_if.wr_n); end
        checks++; if (bus_if.rd_n !== 1'b1) begin errors++; $display("FAIL reset_rd_n: %b, required 1", bus_if.rd_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: %b, required 0", done); end
        @(posedge clk); #1; reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || bus_if.cs_n !== 1'b1) begin
            errors++; $display("FAIL reset_idle: busy=%b cs_n=%b, required 0/1", busy, bus_if.cs_n);
        end
    endtask

    task automatic test_full_burst();
        int c0, r;
        logic [15:0] e, o;
        obs_q.delete(); exp_q.delete();
        push_expected(9'h1FF, DATA_A);
        start_burst(9'h1FF, DATA_A, c0);
        for (int k = 0; k < 9 * XFER + 4; k++) begin
            r = cyc - c0;
            checks++; if (busy !== (r >= 1 && r <= 9 * XFER)) begin
                errors++; $display("FAIL full_busy rel=%0d: %b, required %b", r, busy, (r >= 1 && r <= 9 * XFER));
            end
            checks++; if (done !== (r == 1 + 9 * XFER)) begin
                errors++; $display("FAIL full_done rel=%0d: %b, required %b", r, done, (r == 1 + 9 * XFER));
            end
            @(negedge clk);
        end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL full_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL full_write: addr/data %h/%h, required %h/%h", o[15:8], o[7:0], e[15:8], e[7:0]); end
        end
    endtask

    task automatic test_sparse_mask();
        int c0, r;
        logic [15:0] e, o;
        obs_q.delete(); exp_q.delete();
        push_expected(9'b0_0000_0101, DATA_A);
        start_burst(9'b0_0000_0101, DATA_A, c0);
        for (int k = 0; k < 2 * XFER + 4; k++) begin
            r = cyc - c0;
            checks++; if (busy !== (r >= 1 && r <= 2 * XFER)) begin
                errors++; $display("FAIL sparse_busy rel=%0d: %b, required %b", r, busy, (r >= 1 && r <= 2 * XFER));
            end
            checks++; if (done !== (r == 1 + 2 * XFER)) begin
                errors++; $display("FAIL sparse_done rel=%0d: %b, required %b", r, done, (r == 1 + 2 * XFER));
            end
            @(negedge clk);
        end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL sparse_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sparse_write: addr/data %h/%h, required %h/%h", o[15:8], o[7:0], e[15:8], e[7:0]); end
        end
    endtask

    task automatic test_zero_mask();
        int c0, r;
        obs_q.delete(); exp_q.delete();
        start_burst(9'h000, DATA_B, c0);
        for (int k = 0; k < 10; k++) begin
            r = cyc - c0;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy rel=%0d: %b, required 0", r, busy); end
            checks++; if (done !== (r == 1)) begin errors++; $display("FAIL zero_done rel=%0d: %b, required %b", r, done, (r == 1)); end
            checks++; if (bus_if.cs_n !== 1'b1 || bus_if.ad_oe !== 1'b0) begin
                errors++; $display("FAIL zero_bus rel=%0d: cs_n/ad_oe %b/%b, required 1/0", r, bus_if.cs_n, bus_if.ad_oe);
            end
            @(negedge clk);
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL zero_count: %0d writes, required 0", obs_q.size()); end
    endtask

    task automatic test_snapshot();
        int c0, r;
        logic [15:0] e, o;
        obs_q.delete(); exp_q.delete();
        push_expected(9'h1FF, DATA_A);
        start_burst(9'h1FF, DATA_A, c0);
        for (int k = 0; k < 9 * XFER + 8; k++) begin
            r = cyc - c0;
            checks++; if (busy !== (r >= 1 && r <= 9 * XFER)) begin
                errors++; $display("FAIL snap_busy rel=%0d: %b, required %b", r, busy, (r >= 1 && r <= 9 * XFER));
            end
            checks++; if (done !== (r == 1 + 9 * XFER)) begin
                errors++; $display("FAIL snap_done rel=%0d: %b, required %b", r, done, (r == 1 + 9 * XFER));
            end
            if (r == 20) begin dato_bcd = DATA_B; wr_mask = 9'h001; start = 1'b1; end
            if (r == 21) start = 1'b0;
            @(negedge clk);
        end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL snap_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL snap_write: addr/data %h/%h, required %h/%h", o[15:8], o[7:0], e[15:8], e[7:0]); end
        end
    endtask

    task automatic test_back_to_back();
        int c0, r;
        logic exp_busy, exp_done;
        logic [15:0] e, o;
        obs_q.delete(); exp_q.delete();
        push_expected(9'h004, DATA_A);
        push_expected(9'h100, DATA_B);
        start_burst(9'h004, DATA_A, c0);
        for (int k = 0; k < 2 * XFER + 8; k++) begin
            r = cyc - c0;
            exp_busy = (r >= 1 && r <= XFER) || (r >= XFER + 3 && r <= 2 * XFER + 2);
            exp_done = (r == XFER + 1) || (r == 2 * XFER + 3);
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy rel=%0d: %b, required %b", r, busy, exp_busy); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done rel=%0d: %b, required %b", r, done, exp_done); end
            if (r == XFER + 1) begin wr_mask = 9'h100; dato_bcd = DATA_B; start = 1'b1; end
            if (r == XFER + 3) start = 1'b0;
            @(negedge clk);
        end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_write: addr/data %h/%h, required %h/%h", o[15:8], o[7:0], e[15:8], e[7:0]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int c0, r;
        logic [15:0] e, o;
        obs_q.delete(); exp_q.delete();
        push_expected(9'h007, DATA_A);
        start_burst(9'h1FF, DATA_A, c0);
        // Fourth register (dia) is in its data strobe at relative cycle 3*XFER+10
        for (int k = 1; k < 3 * XFER + 10; k++) @(negedge clk);
        r = cyc - c0;
        checks++; if (bus_if.a_d !== 1'b1 || bus_if.wr_n !== 1'b0 || bus_if.ad_out !== DATA_A[31:24]) begin
            errors++; $display("FAIL rst_mid_phase rel=%0d: a_d/wr_n/ad_out %b/%b/%h, required 1/0/%h",
                               r, bus_if.a_d, bus_if.wr_n, bus_if.ad_out, DATA_A[31:24]);
        end
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        checks++; if (bus_if.cs_n !== 1'b1 || bus_if.wr_n !== 1'b1 || bus_if.ad_oe !== 1'b0) begin
            errors++; $display("FAIL rst_mid_bus: cs_n/wr_n/ad_oe %b/%b/%b, required 1/1/0", bus_if.cs_n, bus_if.wr_n, bus_if.ad_oe);
        end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_status: busy/done %b/%b, required 0/0", busy, done);
        end
        @(posedge clk); #1; reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0 || bus_if.cs_n !== 1'b1) begin
                errors++; $display("FAIL rst_mid_after k=%0d: done/busy/cs_n %b/%b/%b, required 0/0/1", k, done, busy, bus_if.cs_n);
            end
        end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rst_mid_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rst_mid_write: addr/data %h/%h, required %h/%h", o[15:8], o[7:0], e[15:8], e[7:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_sparse_mask();
        test_zero_mask();
        test_snapshot();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
